// File: rtl/lpf_ctrl_pkg.sv
// Shared types and constants for the receive low-pass filter controller.
// Holds the FSM state encoding, code widths and calibration constants.
package lpf_ctrl_pkg;

  localparam int FC_W     = 8;
  localparam int SETTLE_W = 16;
  localparam int CAL_WAIT = 64;

  localparam logic [FC_W-1:0] FC_DEFAULT = 8'h0F;
  localparam logic [FC_W-1:0] SAR_INIT   =
    {1'b1, {(FC_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_OFF,
    S_SETTLE,
    S_ON,
    S_CAL_SET,
    S_CAL_WAIT,
    S_CAL_EVAL
  } state_e;

endpackage

// File: rtl/lpf_ctrl_sar.sv
// Successive-approximation register for cut-off calibration.
// Ports: init loads the MSB trial, step commits/clears the current bit
// using cmp and sets the next lower trial bit; code is the trial value,
// last flags the LSB trial.
module lpf_ctrl_sar
  import lpf_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            init,
  input  logic            step,
  input  logic            cmp,
  output logic [FC_W-1:0] code,
  output logic            last
);

  localparam int IDX_W = $clog2(FC_W);

  logic [FC_W-1:0]  code_q, code_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    code_d = code_q;
    idx_d  = idx_q;
    unique case (1'b1)
      init: begin
        code_d = SAR_INIT;
        idx_d  = IDX_W'(FC_W-1);
      end
      step: begin
        // cmp=1 means the trial overshot: drop this bit
        if (cmp) code_d[idx_q] = 1'b0;
        if (idx_q != '0) begin
          code_d[idx_q - 1'b1] = 1'b1;
          idx_d = idx_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= SAR_INIT;
      idx_q  <= IDX_W'(FC_W-1);
    end else begin
      code_q <= code_d;
      idx_q  <= idx_d;
    end
  end

  assign code = code_q;
  assign last = (idx_q == '0);

endmodule

// File: rtl/lpf_ctrl.sv
// Low-pass filter controller: power sequencing, glitch-free cut-off
// updates with settle time, and 8-step SAR cut-off calibration.
// Ports: en/fc_cfg/use_cal/settle_cycles/cal_start/cal_cmp in;
// lpf_pd/lpf_fc/ready/cal_busy/cal_done/cal_code out (all registered).
module lpf_ctrl
  import lpf_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [FC_W-1:0]     fc_cfg,
  input  logic                use_cal,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic                cal_start,
  input  logic                cal_cmp,
  output logic                lpf_pd,
  output logic [FC_W-1:0]     lpf_fc,
  output logic                ready,
  output logic                cal_busy,
  output logic                cal_done,
  output logic [FC_W-1:0]     cal_code
);

  state_e              state_q, state_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic                pd_q, pd_d;
  logic [FC_W-1:0]     fc_q, fc_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [FC_W-1:0]     code_q, code_d;

  logic            sar_init, sar_step, sar_last;
  logic [FC_W-1:0] sar_code, sel, cal_final;

  lpf_ctrl_sar u_sar (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (sar_init),
    .step  (sar_step),
    .cmp   (cal_cmp),
    .code  (sar_code),
    .last  (sar_last)
  );

  assign sel = (use_cal && done_q) ? code_q : fc_cfg;
  // result of the final (LSB) trial, needed in the same cycle
  assign cal_final = {sar_code[FC_W-1:1], sar_code[0] & ~cal_cmp};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pd_d     = pd_q;
    fc_d     = fc_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    done_d   = done_q;
    code_d   = code_q;
    sar_init = 1'b0;
    sar_step = 1'b0;
    if (!en) begin
      state_d = S_OFF;
      pd_d    = 1'b1;
      fc_d    = FC_DEFAULT;
      ready_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_OFF: begin
          pd_d    = 1'b0;
          fc_d    = sel;
          cnt_d   = settle_cycles;
          state_d = S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            ready_d = 1'b1;
            state_d = S_ON;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_ON: begin
          if (cal_start) begin
            busy_d   = 1'b1;
            ready_d  = 1'b0;
            sar_init = 1'b1;
            state_d  = S_CAL_SET;
          end else if (sel != fc_q) begin
            fc_d    = sel;
            cnt_d   = settle_cycles;
            ready_d = 1'b0;
            state_d = S_SETTLE;
          end
        end
        S_CAL_SET: begin
          fc_d    = sar_code;
          cnt_d   = SETTLE_W'(CAL_WAIT-1);
          state_d = S_CAL_WAIT;
        end
        S_CAL_WAIT: begin
          if (cnt_q == '0) state_d = S_CAL_EVAL;
          else             cnt_d   = cnt_q - 1'b1;
        end
        S_CAL_EVAL: begin
          sar_step = 1'b1;
          if (sar_last) begin
            code_d  = cal_final;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            fc_d    = use_cal ? cal_final : fc_cfg;
            cnt_d   = settle_cycles;
            state_d = S_SETTLE;
          end else begin
            state_d = S_CAL_SET;
          end
        end
        default: state_d = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      pd_q    <= 1'b1;
      fc_q    <= FC_DEFAULT;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      code_q  <= FC_DEFAULT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pd_q    <= pd_d;
      fc_q    <= fc_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      code_q  <= code_d;
    end
  end

  assign lpf_pd   = pd_q;
  assign lpf_fc   = fc_q;
  assign ready    = ready_q;
  assign cal_busy = busy_q;
  assign cal_done = done_q;
  assign cal_code = code_q;

endmodule

// File: doc/lpf_ctrl.md
Name: lpf_ctrl

Overview:
- Digital controller for the receiver channel low-pass filter.
- Sequences the filter's power-down input, applies a glitch-free cut-off code and enforces a settle time after every power-up or retune.
- Runs an 8-step successive-approximation (SAR) calibration of the cut-off code against an analog comparator flag.
- Sits between the SoC register file and the filter's pd/fc pins.

Parameters:
FC_W, 8, cut-off code width
FC_DEFAULT, 8'h0F, code driven at reset and while powered down
SETTLE_W, 16, width of the settle counter and of settle_cycles
CAL_WAIT, 64, cycles to wait after each calibration code change before sampling cal_cmp

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  filter enable from SoC; 0 = powered down
fc_cfg  in  FC_W  software cut-off code
use_cal  in  1  1 = drive cal_code instead of fc_cfg once calibrated
settle_cycles  in  SETTLE_W  settle time in clk cycles
cal_start  in  1  single-cycle calibration request
cal_cmp  in  1  comparator: 1 = measured corner above target
lpf_pd  out  1  filter power-down
lpf_fc  out  FC_W  filter cut-off code
ready  out  1  filter output valid
cal_busy  out  1  calibration in progress
cal_done  out  1  sticky: a calibration has completed
cal_code  out  FC_W  last calibrated code

Behaviour:
- Reset values: lpf_pd=1, lpf_fc=FC_DEFAULT, ready=0, cal_busy=0, cal_done=0, cal_code=FC_DEFAULT; state=OFF.
- All outputs are registered.
- States: OFF, SETTLE, ON, CAL_SET, CAL_WAIT, CAL_EVAL.
- OFF:
  - lpf_pd=1, lpf_fc=FC_DEFAULT.
  - en=1 -> load lpf_fc with the selected code (cal_code if use_cal&cal_done, else fc_cfg), lpf_pd=0, counter=settle_cycles, go to SETTLE.
- SETTLE:
  - Counter decrements each cycle; ready=0.
  - Exits to ON on the cycle after the counter reads 0, so settle_cycles=0 still gives one SETTLE cycle and latency en->ready = settle_cycles+2 cycles.
- ON:
  - ready=1.
  - If the selected code differs from lpf_fc: load it, reload the counter, go to SETTLE. pd stays 0; this is a retune.
  - cal_start=1 -> cal_busy=1, ready=0, SAR register=1000_0000, bit index=FC_W-1, go to CAL_SET.
  - cal_start has priority over a same-cycle retune.
- CAL_SET: lpf_fc=SAR register; counter=CAL_WAIT-1; go to CAL_WAIT.
- CAL_WAIT: count to 0, then go to CAL_EVAL.
- CAL_EVAL:
  - Sample cal_cmp; if 1, clear the current SAR bit.
  - If bit index>0: set the next lower bit, decrement the index, go to CAL_SET.
  - Else: cal_code=SAR, cal_done=1, cal_busy=0, go to SETTLE with lpf_fc=selected code (re-evaluated with the new cal_code).
- Calibration cycle count: 8 iterations x (CAL_WAIT+2) cycles.
- cal_start is ignored outside ON; it is neither queued nor counted.
- en=0 in any state: next cycle state=OFF, lpf_pd=1, lpf_fc=FC_DEFAULT, ready=0, cal_busy=0.
  - Aborted calibration leaves cal_code and cal_done unchanged.
- cal_done is cleared only by reset.
- fc_cfg/use_cal changes during SETTLE or calibration are not acted on immediately; they are picked up by the mismatch check once in ON.
- Asynchronous reset mid-operation returns all outputs to reset values immediately.

Decomposition:
- Package lpf_ctrl_pkg holds:
  - state enum typedef;
  - FC_DEFAULT;
  - SAR initial-value constant.
- One sub-module, lpf_ctrl_sar: SAR register, bit index and trial/commit logic. Controls: init, step, cmp. Outputs: code, last.
- Settle/wait counter stays inline.

Test Plan:
1. Power-up: reset, settle_cycles=10, fc_cfg=8'h0F, en=1 -> lpf_pd falls 1 cycle later, lpf_fc=8'h0F, ready rises exactly 12 cycles after en.
2. Retune: in ON, fc_cfg 8'h0F->8'h20 -> lpf_fc=8'h20 next cycle, ready low for 11 cycles, lpf_pd stays 0 throughout.
3. Calibration: model cal_cmp = (lpf_fc > 8'h5A), cal_start pulse -> lpf_fc steps 80,40,60,50,58,5C,5A,5B. Final result: cal_code=8'h5A, cal_done=1, cal_busy=0. Total duration 8x(CAL_WAIT+2) cycles, then SETTLE with use_cal=1 -> lpf_fc=8'h5A.
4. Abort: en=0 during the 3rd calibration step -> next cycle lpf_pd=1, lpf_fc=8'h0F, cal_busy=0, cal_done and cal_code unchanged.
5. Edge cases:
   - settle_cycles=0 -> ready 2 cycles after en.
   - cal_start in OFF or SETTLE -> no calibration; cal_busy stays 0.
6. Async reset asserted mid-CAL_WAIT -> all outputs at reset values without a clock edge.
